// File: rtl/wwvb_pkg.sv
// WWVB symbol codes, keyed durations and encoder state type.
// Latency: n/a (constants only). Backpressure: n/a.
// Shared by wwvb_symbol_encoder and its bench-facing users.
package wwvb_pkg;

  localparam logic [1:0] SYM_ZERO    = 2'b00;
  localparam logic [1:0] SYM_ONE     = 2'b01;
  localparam logic [1:0] SYM_MARKER  = 2'b10;
  localparam logic [1:0] SYM_INVALID = 2'b11;

  localparam logic [9:0] DUR_ZERO_MS   = 10'd200;
  localparam logic [9:0] DUR_ONE_MS    = 10'd500;
  localparam logic [9:0] DUR_MARKER_MS = 10'd800;
  localparam logic [9:0] MS_LAST       = 10'd999;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Invalid code is keyed as a marker.
  function automatic logic [9:0] sym_dur_ms(input logic [1:0] sym);
    case (sym)
      SYM_ZERO: return DUR_ZERO_MS;
      SYM_ONE:  return DUR_ONE_MS;
      default:  return DUR_MARKER_MS;
    endcase
  endfunction

endpackage

// File: rtl/wwvb_symbol_encoder_ms_tick_gen.sv
// Millisecond prescaler: ms_tick pulses on the last of every PRE enabled cycles.
// Latency: tick is combinational from the registered prescale count.
// Backpressure: none; clr holds the count at 0, en gates counting.
module ms_tick_gen #(
  parameter int PRE = 48000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic ms_tick
);

  localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);

  logic [PW-1:0] pre_cnt;

  assign ms_tick = en && (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= ms_tick ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wwvb_symbol_encoder.sv
// WWVB keyer: zero/one/marker -> 200/500/800 ms reduced carrier per second (WWVB_UNDERRUN_MARKER_EN keys marker on underrun).
// Latency: accept in IDLE shows active/frame_start/out_low next cycle; every output registered.
// Backpressure: one holding slot; sym_ready low while full, returns the cycle after end of second.
module wwvb_symbol_encoder #(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int UNDERRUN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sym_valid,
  input  logic [1:0]            sym_data,
  output logic                  sym_ready,
  output logic                  out_low,
  output logic                  active,
  output logic                  frame_start,
  output logic                  sym_err,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);
  import wwvb_pkg::*;

  localparam int PRE = CLK_FREQ / 1000;

  state_t     state, state_n;
  logic [9:0] ms_cnt, ms_cnt_n;
  logic [1:0] cur_sym, cur_sym_n;
  logic [1:0] slot_sym, slot_sym_n;
  logic       slot_full, slot_full_n;
  logic       ms_tick, accept, eos, underrun, frame_start_n;

  ms_tick_gen #(.PRE(PRE)) u_ms_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_RUN),
    .en      (state == ST_RUN),
    .ms_tick (ms_tick)
  );

  assign accept = sym_valid && sym_ready;
  assign eos    = ms_tick && (ms_cnt == MS_LAST);

  always_comb begin
    state_n       = state;
    ms_cnt_n      = ms_cnt;
    cur_sym_n     = cur_sym;
    slot_sym_n    = slot_sym;
    slot_full_n   = slot_full;
    underrun      = 1'b0;
    frame_start_n = 1'b0;
    case (state)
      ST_IDLE: begin
        ms_cnt_n = '0;
        if (accept) begin
          cur_sym_n     = sym_data;
          state_n       = ST_RUN;
          frame_start_n = 1'b1;
        end
      end
      ST_RUN: begin
        if (ms_tick) ms_cnt_n = (ms_cnt == MS_LAST) ? '0 : ms_cnt + 1'b1;
        if (eos) begin
          frame_start_n = 1'b1;
          if (slot_full) begin
            cur_sym_n   = slot_sym;
            slot_full_n = 1'b0;
          end else if (accept) begin
            // Symbol arriving exactly at end of second skips the slot.
            cur_sym_n = sym_data;
          end else begin
            underrun = 1'b1;
`ifdef WWVB_UNDERRUN_MARKER_EN
            cur_sym_n = SYM_MARKER;
`else
            state_n       = ST_IDLE;
            frame_start_n = 1'b0;
`endif
          end
        end else if (accept) begin
          slot_sym_n  = sym_data;
          slot_full_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ms_cnt       <= '0;
      cur_sym      <= SYM_ZERO;
      slot_sym     <= SYM_ZERO;
      slot_full    <= 1'b0;
      out_low      <= 1'b0;
      active       <= 1'b0;
      frame_start  <= 1'b0;
      sym_ready    <= 1'b1;
      sym_err      <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state       <= state_n;
      ms_cnt      <= ms_cnt_n;
      cur_sym     <= cur_sym_n;
      slot_sym    <= slot_sym_n;
      slot_full   <= slot_full_n;
      // Outputs are computed from next-state so they line up with the counters.
      out_low     <= (state_n == ST_RUN) && (ms_cnt_n < sym_dur_ms(cur_sym_n));
      active      <= (state_n == ST_RUN);
      frame_start <= frame_start_n;
      sym_ready   <= (state_n == ST_IDLE) || !slot_full_n;
      if (accept && (sym_data == SYM_INVALID)) sym_err <= 1'b1;
      if (underrun && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule
